// File: rtl/aes_ctr_keystream_ctrl.sv
// AES-CTR keystream sequencer around an external pipelined aes_128 core.
// Issues counter blocks under FIFO credit, tracks in-flight blocks and buffers results.
module aes_ctr_keystream_ctrl #(
  parameter int DATA_W     = 128,
  parameter int CORE_LAT   = 21,
  parameter int FIFO_DEPTH = 32,
  parameter int CTR_W      = 32,
  parameter int LEN_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DATA_W-1:0] cfg_key,
  input  logic [DATA_W-1:0] cfg_iv,
  input  logic [LEN_W-1:0]  cfg_nblocks,
  input  logic              abort,
  output logic [DATA_W-1:0] core_state,
  output logic [DATA_W-1:0] core_key,
  input  logic [DATA_W-1:0] core_out,
  output logic              ks_valid,
  input  logic              ks_ready,
  output logic [DATA_W-1:0] ks_data,
  output logic              busy,
  output logic              done
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   key_q, key_d;
  logic [DATA_W-1:0]   ctr_q, ctr_d;
  logic [LEN_W-1:0]    nblocks_q, nblocks_d;
  logic [LEN_W-1:0]    issued_q, issued_d;
  logic [CORE_LAT-1:0] vsr_q, vsr_d;
  logic [CNT_W-1:0]    inflight_q, inflight_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];

  logic                issue_en, push, pop, has_credit;
  logic [CNT_W:0]      occupancy;

  assign cfg_ready  = (state_q == ST_IDLE);
  assign busy       = !cfg_ready;
  assign ks_valid   = (count_q != '0);
  assign ks_data    = ks_valid ? mem_q[rd_ptr_q] : '0;
  assign core_state = ctr_q;
  assign core_key   = key_q;

  // Credit counts blocks still in the core so every issued block has a FIFO slot.
  assign occupancy  = {1'b0, count_q} + {1'b0, inflight_q};
  assign has_credit = occupancy < (CNT_W + 1)'(FIFO_DEPTH);
  assign issue_en   = (state_q == ST_RUN) && (issued_q < nblocks_q) && has_credit && !abort;
  assign push       = vsr_q[CORE_LAT-1] && !abort;
  assign pop        = ks_valid && ks_ready;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path infers a latch.
    state_d    = state_q;
    key_d      = key_q;
    ctr_d      = ctr_q;
    nblocks_d  = nblocks_q;
    issued_d   = issued_q;
    done       = 1'b0;
    vsr_d      = (vsr_q << 1) | CORE_LAT'(issue_en);
    inflight_d = inflight_q + CNT_W'(issue_en) - CNT_W'(vsr_q[CORE_LAT-1]);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);

    if (issue_en) begin
      ctr_d    = {ctr_q[DATA_W-1:CTR_W], ctr_q[CTR_W-1:0] + CTR_W'(1)};
      issued_d = issued_q + LEN_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          key_d     = cfg_key;
          ctr_d     = cfg_iv;
          nblocks_d = cfg_nblocks;
          issued_d  = '0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (nblocks_q == '0) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end else if (issue_en && (issued_q == nblocks_q - LEN_W'(1))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((inflight_q == '0) &&
            ((count_q == '0) || ((count_q == CNT_W'(1)) && pop))) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort flushes everything in flight; results still emerging from the core are dropped.
    if (abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      done       = 1'b0;
      ctr_d      = '0;
      issued_d   = '0;
      vsr_d      = '0;
      inflight_d = '0;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      key_q      <= '0;
      ctr_q      <= '0;
      nblocks_q  <= '0;
      issued_q   <= '0;
      vsr_q      <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      ctr_q      <= ctr_d;
      nblocks_q  <= nblocks_d;
      issued_q   <= issued_d;
      vsr_q      <= vsr_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; clearing the pointers and count empties the FIFO.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= core_out;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (count_q == CNT_W'(FIFO_DEPTH))));

endmodule
